// File: rtl/fwd_slice_pkg.sv
// Shared types and helpers for the forward-registered handshake slice.
// State names cover both the base slice and the FWD_SLICE_SKID_EN build.
package fwd_slice_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } slice_state_e;

  // A modulus below 2 would give a zero-width counter, so clamp to one bit.
  function automatic int cnt_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/handshake_beat_counter.sv
// Modulo-DEPTH beat counter with a registered wrap pulse.
// Shared by the forward- and backward-registered slices for frame bookkeeping.
module handshake_beat_counter
  import fwd_slice_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          s_rst_n,
  input  logic          inc,
  output logic [CW-1:0] beat_cnt,
  output logic          cnt_wrap
);

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic at_last;

  assign at_last = (beat_cnt == LAST);

  // Explicit compare against DEPTH-1 so non-power-of-two moduli wrap correctly.
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      beat_cnt <= '0;
      cnt_wrap <= 1'b0;
    end else begin
      cnt_wrap <= inc & at_last;
      if (inc) begin
        beat_cnt <= at_last ? '0 : beat_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/forward_registered_slice.sv
// Forward-registered valid/ready slice: dst valid/data come straight from flops.
// Define FWD_SLICE_SKID_EN to add a skid register and a registered src_ready.
module forward_registered_slice
  import fwd_slice_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic             src_vaild,
  input  logic [WIDTH-1:0] src_data_in,
  output logic             src_ready,
  input  logic             dst_ready,
  output logic             dst_vaild,
  output logic [WIDTH-1:0] dst_data_out,
  output logic             idle,
  output logic [CW-1:0]    beat_cnt,
  output logic             cnt_wrap
);

  slice_state_e     state;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             idle_q;
  logic             src_fire;
  logic             dst_fire;
  logic             next_empty;

  assign src_fire     = src_vaild & src_ready;
  assign dst_fire     = valid_q & dst_ready;
  assign dst_vaild    = valid_q;
  assign dst_data_out = data_q;
  assign idle         = idle_q;

`ifdef FWD_SLICE_SKID_EN

  logic [WIDTH-1:0] skid_q;
  logic             skid_full;

  // src_ready depends only on the skid flop, gated low while reset is held.
  assign src_ready  = s_rst_n & ~skid_full;
  assign next_empty = ~src_fire &
                      ((state == ST_EMPTY) | ((state == ST_BUSY) & dst_ready));

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= ST_EMPTY;
      valid_q   <= 1'b0;
      data_q    <= '0;
      skid_q    <= '0;
      skid_full <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      idle_q <= next_empty & ~src_vaild;
      case (state)
        ST_EMPTY: begin
          if (src_fire) begin
            state   <= ST_BUSY;
            valid_q <= 1'b1;
            data_q  <= src_data_in;
          end
        end
        ST_BUSY: begin
          if (dst_fire) begin
            if (src_fire) begin
              data_q <= src_data_in;
            end else begin
              state   <= ST_EMPTY;
              valid_q <= 1'b0;
            end
          end else if (src_fire) begin
            state     <= ST_FULL;
            skid_q    <= src_data_in;
            skid_full <= 1'b1;
          end
        end
        ST_FULL: begin
          // No acceptance here; the skid beat is promoted once main drains.
          if (dst_fire) begin
            state     <= ST_BUSY;
            data_q    <= skid_q;
            skid_full <= 1'b0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          valid_q   <= 1'b0;
          skid_full <= 1'b0;
        end
      endcase
    end
  end

`else

  // The one combinational path: accept when empty or when the held beat leaves.
  assign src_ready  = s_rst_n & (~valid_q | dst_ready);
  assign next_empty = ~src_fire & (~valid_q | dst_ready);

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      data_q  <= '0;
      idle_q  <= 1'b1;
    end else begin
      idle_q <= next_empty & ~src_vaild;
      case (state)
        ST_EMPTY: begin
          if (src_fire) begin
            state   <= ST_FULL;
            valid_q <= 1'b1;
            data_q  <= src_data_in;
          end
        end
        ST_FULL: begin
          if (dst_fire) begin
            if (src_fire) begin
              data_q <= src_data_in;
            end else begin
              state   <= ST_EMPTY;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`endif

  handshake_beat_counter #(
    .DEPTH(DEPTH)
  ) u_beat_counter (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .inc     (dst_fire),
    .beat_cnt(beat_cnt),
    .cnt_wrap(cnt_wrap)
  );

endmodule
